native_port_arbiter: RTL and testbench
======================================

# native_port_arbiter

Shares one valid-ready native memory port among NUM_REQ cache-side bridges, for example separate I-cache and D-cache bridges. It grants one requester at a time and forwards that requester's request downstream. It tracks the single outstanding read and routes the native update (read response) back to the requester that issued it. The block sits between the per-cache bridges and the native memory/interconnect port.

## Interface
- NUM_REQ, 2, number of requesters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 256, line width
- clk  in  1  clock
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_op  in  2*NUM_REQ  per-requester op, flattened (bits [2i+1:2i]); 01 read, 10 write
- req_addr  in  ADDR_WIDTH*NUM_REQ  per-requester address, flattened
- req_data  in  DATA_WIDTH*NUM_REQ  per-requester write data, flattened
- upd_valid  out  NUM_REQ  per-requester response valid
- upd_ready  in  NUM_REQ  per-requester response accept
- upd_data  out  DATA_WIDTH  response data, broadcast to all requesters
- nat_request_valid / nat_request_ready  out/in  1  downstream request handshake
- nat_request_op  out  2  downstream op
- nat_request_addr  out  ADDR_WIDTH  downstream address
- nat_request_data  out  DATA_WIDTH  downstream write data
- nat_update_valid / nat_update_ready  in/out  1  downstream response handshake
- nat_update_data  in  DATA_WIDTH  downstream response data

## Operation
- FSM has three states: IDLE, REQ, RESP. A registered owner index holds the granted requester. Reset: IDLE, owner 0.
- **IDLE**
  - If any req_valid is high, pick a winner, latch it as owner, and go to REQ.
  - No req_ready is asserted in IDLE.
- **REQ**
  - nat_request_valid=1.
  - nat_request_op, nat_request_addr and nat_request_data are muxed combinationally from the owner's inputs.
  - Requesters hold their inputs stable while valid and not ready.
  - req_ready[owner]=nat_request_ready; every other req_ready bit is 0.
  - On handshake: op 01 goes to RESP; any other op goes to IDLE. Ops 00 and 11 are forwarded unchanged and expect no response.
- **RESP**
  - upd_valid[owner]=nat_update_valid.
  - nat_update_ready=upd_ready[owner].
  - upd_data=nat_update_data.
  - On response handshake, go to IDLE.
  - No new request is granted while in RESP; this preserves ordering and allows exactly one outstanding read.
- **Outside their active state:** nat_request_valid, nat_request_op, nat_request_addr, nat_request_data, all upd_valid bits and nat_update_ready are forced to 0.
- **Unexpected response:** nat_update_valid outside RESP is ignored, since nat_update_ready=0.

## Timing
- **Reset:** every output is 0. Async assert; deassert is sampled on the clk rising edge.
- **Request latency:** req_valid high in IDLE at cycle t gives nat_request_valid at t+1. A request that is ready at t+1 completes the write in 2 cycles.
- **Next grant:** the earliest next grant decision is the cycle after returning to IDLE. Maximum throughput is one request per 2 cycles (writes) or 3+ cycles (reads).
- **Response path:** combinational, zero added latency. Back-pressure from upd_ready passes straight through to nat_update_ready.
- **Reset mid-operation:** an in-flight read is dropped. The downstream side must be reset together with this block.
- **Withdrawn request:** a requester dropping req_valid before handshake is illegal. Behaviour is undefined and flagged by assertion.

## Configuration
- **NATIVE_ARB_RR_EN defined:** round-robin arbitration.
  - A last-grant pointer, reset to NUM_REQ-1, is updated on every IDLE→REQ transition.
  - The search starts at pointer+1, modulo NUM_REQ.
  - With both requesters always requesting, grants alternate 0,1,0,1.
- **NATIVE_ARB_RR_EN undefined:** fixed priority, lowest index wins. No pointer register.

## Structure
- **Package native_pkg:**
  - Op constants NAT_OP_NONE=2'b00, NAT_OP_READ=2'b01, NAT_OP_WRITE=2'b10.
  - typedef enum logic [1:0] arb_state_t {IDLE, REQ, RESP}.
- **Sub-module rr_arbiter (NUM_REQ):**
  - Inputs: request vector and pointer. Output: one-hot grant plus index.
  - Combinational; the pointer lives in the parent.
  - With the macro undefined, it is instantiated with the pointer tied to NUM_REQ-1.

## Test plan
- **Write pass-through:** req 0 issues a write, addr 0x100, data all-0xA5, downstream always ready. Required: nat_request_valid at t+1 with op 10, addr 0x100; req_ready[0] pulses once; back to IDLE at t+2; no upd_valid.
- **Read routing:** req 1 reads addr 0x2E0; downstream returns data 0x1234 after 5 cycles. Required: upd_valid[1]=1 with upd_data=0x1234; upd_valid[0] stays 0.
- **Contention:** both requesters issue reads simultaneously, each back-to-back for 4 transactions.
  - RR defined: grant order 0,1,0,1.
  - RR undefined: requester 0 is always granted while it requests.
- **Back-pressure:** read outstanding with upd_ready[owner]=0 for 3 cycles. Required: nat_update_ready=0 for those cycles, FSM stays in RESP, a pending write from the other requester is not granted until the response handshake.
- **Reset mid-read:** resetn asserted during RESP. Required: all outputs 0 immediately (asynchronously); FSM in IDLE and new requests granted normally after release.
- **Stray response:** nat_update_valid=1 in IDLE. Required: nat_update_ready=0 and no upd_valid asserted.

Source files
------------

// File: rtl/native_pkg.sv
// native_pkg: op encodings and FSM state type shared by the native port arbiter and its arbiter core.
package native_pkg;

    localparam logic [1:0] NAT_OP_NONE  = 2'b00;
    localparam logic [1:0] NAT_OP_READ  = 2'b01;
    localparam logic [1:0] NAT_OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick; the search starts one past ptr_i.
// A pointer of NUM_REQ-1 degenerates to fixed priority with index 0 highest.
module rr_arbiter
    import native_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/native_port_arbiter.sv
// native_port_arbiter: shares one valid-ready native memory port among NUM_REQ bridges, one read outstanding.
// Define NATIVE_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module native_port_arbiter
    import native_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]             upd_valid,
    input  logic [NUM_REQ-1:0]             upd_ready,
    output logic [DATA_WIDTH-1:0]          upd_data,
    output logic                           nat_request_valid,
    input  logic                           nat_request_ready,
    output logic [1:0]                     nat_request_op,
    output logic [ADDR_WIDTH-1:0]          nat_request_addr,
    output logic [DATA_WIDTH-1:0]          nat_request_data,
    input  logic                           nat_update_valid,
    output logic                           nat_update_ready,
    input  logic [DATA_WIDTH-1:0]          nat_update_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [NUM_REQ-1:0]     win_gnt;
    logic [1:0]             own_op;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

`ifdef NATIVE_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (state_q == IDLE && |win_gnt) begin
            ptr_q <= win_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = IDX_W'(NUM_REQ - 1);
`endif

    assign own_op   = req_op[2*owner_q +: 2];
    assign own_addr = req_addr[ADDR_WIDTH*owner_q +: ADDR_WIDTH];
    assign own_data = req_data[DATA_WIDTH*owner_q +: DATA_WIDTH];

    // Only reads wait for a response; every other op frees the port on handshake.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|win_gnt) begin
                    owner_d = win_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (nat_request_ready) begin
                    state_d = (own_op == NAT_OP_READ) ? RESP : IDLE;
                end
            end
            RESP: begin
                if (nat_update_valid && upd_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        req_ready         = '0;
        nat_request_valid = 1'b0;
        nat_request_op    = '0;
        nat_request_addr  = '0;
        nat_request_data  = '0;
        upd_valid         = '0;
        nat_update_ready  = 1'b0;
        upd_data          = '0;
        if (state_q == REQ) begin
            nat_request_valid  = 1'b1;
            nat_request_op     = own_op;
            nat_request_addr   = own_addr;
            nat_request_data   = own_data;
            req_ready[owner_q] = nat_request_ready;
        end
        if (state_q == RESP) begin
            upd_valid[owner_q] = nat_update_valid;
            nat_update_ready   = upd_ready[owner_q];
            upd_data           = nat_update_data;
        end
    end

`ifndef SYNTHESIS
    // A granted requester may not withdraw before its request is accepted.
    a_req_held: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == REQ) |-> req_valid[owner_q]);
`endif

endmodule

// File: tb/tb_native_port_arbiter.sv
// tb_native_port_arbiter: transaction-level bench with per-requester request queues and a grant-rule model.
module tb_native_port_arbiter;
    import native_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 256;
    localparam int QD      = 64;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req_valid, req_ready, upd_valid, upd_ready;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [AW*NUM_REQ-1:0] req_addr;
    logic [DW*NUM_REQ-1:0] req_data;
    logic [DW-1:0]         upd_data, nat_request_data, nat_update_data;
    logic                  nat_request_valid, nat_request_ready, nat_update_valid, nat_update_ready;
    logic [1:0]            nat_request_op;
    logic [AW-1:0]         nat_request_addr;

    always #5 clk = ~clk;

    native_port_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .upd_valid         (upd_valid),
        .upd_ready         (upd_ready),
        .upd_data          (upd_data),
        .nat_request_valid (nat_request_valid),
        .nat_request_ready (nat_request_ready),
        .nat_request_op    (nat_request_op),
        .nat_request_addr  (nat_request_addr),
        .nat_request_data  (nat_request_data),
        .nat_update_valid  (nat_update_valid),
        .nat_update_ready  (nat_update_ready),
        .nat_update_data   (nat_update_data)
    );

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t fifo [NUM_REQ][QD];
    int   hd [NUM_REQ];
    int   tl [NUM_REQ];
    int   last_gnt;
    int   gnt_log[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = NUM_REQ'(1) << i;
        return v;
    endfunction

    function automatic bit bit_of(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Grant rule: rotate from the last winner, or lowest index when round-robin is off.
    function automatic int pick(input logic [NUM_REQ-1:0] mask);
`ifdef NATIVE_ARB_RR_EN
        for (int k = 1; k <= NUM_REQ; k++)
            if (bit_of(mask, (last_gnt + k) % NUM_REQ)) return (last_gnt + k) % NUM_REQ;
`else
        for (int k = 0; k < NUM_REQ; k++)
            if (bit_of(mask, k)) return k;
`endif
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NUM_REQ; i++) if (hd[i] != tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int r, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        fifo[r][tl[r] % QD].op   = op;
        fifo[r][tl[r] % QD].addr = a;
        fifo[r][tl[r] % QD].data = d;
        tl[r]++;
    endtask

    task automatic drive_reqs();
        txn_t t;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hd[i] != tl[i]) begin
                t = fifo[i][hd[i] % QD];
                req_valid = req_valid | onehot(i);
            end else begin
                t.op   = 2'($urandom);
                t.addr = $urandom;
                t.data = rand_wide();
                req_valid = req_valid & ~onehot(i);
            end
            req_op[2*i +: 2]     = t.op;
            req_addr[AW*i +: AW] = t.addr;
            req_data[DW*i +: DW] = t.data;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_nat_req_valid"}, nat_request_valid, 1'b0);
        check({tag, "_nat_req_op"}, nat_request_op, '0);
        check({tag, "_nat_req_addr"}, nat_request_addr, '0);
        check({tag, "_nat_req_data"}, nat_request_data, '0);
        check({tag, "_upd_valid"}, upd_valid, '0);
        check({tag, "_nat_upd_ready"}, nat_update_ready, 1'b0);
        check({tag, "_upd_data"}, upd_data, '0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive_reqs();
            nat_request_ready = 1'($urandom);
            nat_update_valid  = 1'b1;
            upd_ready         = NUM_REQ'($urandom);
            nat_update_data   = rand_wide();
            #3;
            check("idle_nat_req_valid", nat_request_valid, 1'b0);
            check("idle_req_ready", req_ready, '0);
            check("stray_nat_upd_ready", nat_update_ready, 1'b0);
            check("stray_upd_valid", upd_valid, '0);
            cyc();
        end
    endtask

    // One grant, request phase and (for reads) response phase, all from the IDLE cycle onward.
    task automatic run_txn(input int req_dly, input int resp_dly, input int bp, input logic [DW-1:0] rdata);
        logic [NUM_REQ-1:0] mask, exp_ur;
        int   w, last_k;
        txn_t t;
        drive_reqs();
        nat_request_ready = 1'($urandom);
        nat_update_valid  = 1'($urandom);
        upd_ready         = NUM_REQ'($urandom);
        nat_update_data   = rand_wide();
        mask = req_valid;
        #3;
        check("grant_cycle_nat_req_valid", nat_request_valid, 1'b0);
        check("grant_cycle_req_ready", req_ready, '0);
        check("grant_cycle_upd_valid", upd_valid, '0);
        w = pick(mask);
        if (w < 0) begin
            check("grant_cycle_pending", mask, '1);
            cyc();
            return;
        end
        t = fifo[w][hd[w] % QD];
        gnt_log.push_back(w);
        cyc();
        for (int k = 0; k <= req_dly; k++) begin
            drive_reqs();
            nat_request_ready = (k == req_dly);
            nat_update_valid  = 1'($urandom);
            upd_ready         = NUM_REQ'($urandom);
            exp_ur            = (k == req_dly) ? onehot(w) : '0;
            #3;
            check("req_nat_valid", nat_request_valid, 1'b1);
            check("req_nat_op", nat_request_op, t.op);
            check("req_nat_addr", nat_request_addr, t.addr);
            check("req_nat_data", nat_request_data, t.data);
            check("req_ready", req_ready, exp_ur);
            check("req_upd_valid", upd_valid, '0);
            check("req_nat_upd_ready", nat_update_ready, 1'b0);
            cyc();
        end
        hd[w]++;
        last_gnt = w;
        if (t.op == NAT_OP_READ) begin
            last_k = resp_dly + bp;
            for (int k = 0; k <= last_k; k++) begin
                drive_reqs();
                nat_request_ready = 1'($urandom);
                nat_update_valid  = (k >= resp_dly);
                upd_ready         = NUM_REQ'($urandom);
                if (k >= resp_dly && k < last_k) upd_ready = upd_ready & ~onehot(w);
                if (k == last_k) upd_ready = upd_ready | onehot(w);
                nat_update_data   = (k >= resp_dly) ? rdata : rand_wide();
                #3;
                check("resp_nat_req_valid", nat_request_valid, 1'b0);
                check("resp_req_ready", req_ready, '0);
                check("resp_upd_valid", upd_valid, nat_update_valid ? onehot(w) : '0);
                check("resp_nat_upd_ready", nat_update_ready, bit_of(upd_ready, w));
                if (nat_update_valid) check("resp_upd_data", upd_data, rdata);
                cyc();
            end
        end
    endtask

    int exp_order[8];

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        last_gnt          = NUM_REQ - 1;
        resetn            = 1'b0;
        req_valid         = '1;
        req_op            = '1;
        req_addr          = '1;
        req_data          = '1;
        upd_ready         = '1;
        nat_request_ready = 1'b1;
        nat_update_valid  = 1'b1;
        nat_update_data   = '1;
        #3;
        check_all_zero("reset");
        cyc();
        cyc();
        resetn = 1'b1;

        // Write pass-through from requester 0.
        push(0, NAT_OP_WRITE, 32'h100, {32{8'hA5}});
        run_txn(0, 0, 0, '0);
        idle_cycles(1);

        // Read routing to requester 1.
        push(1, NAT_OP_READ, 32'h2E0, rand_wide());
        run_txn(0, 5, 0, DW'(32'h1234));

        // Stray responses while idle.
        idle_cycles(3);

        // Contention: four back-to-back reads from each requester.
        for (int j = 0; j < 4; j++) begin
            push(0, NAT_OP_READ, $urandom, rand_wide());
            push(1, NAT_OP_READ, $urandom, rand_wide());
        end
        gnt_log.delete();
        for (int j = 0; j < 8; j++)
            run_txn($urandom_range(0, 1), $urandom_range(0, 2), 0, rand_wide());
`ifdef NATIVE_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        check("contention_count", gnt_log.size(), 8);
        for (int j = 0; j < 8 && j < gnt_log.size(); j++)
            check($sformatf("contention_grant%0d", j), gnt_log[j], exp_order[j]);

        // Back-pressure: read held 3 cycles while a write from the other requester waits.
        push(0, NAT_OP_READ, 32'h80, rand_wide());
        push(1, NAT_OP_WRITE, 32'hC0, rand_wide());
        gnt_log.delete();
        run_txn(0, 1, 3, rand_wide());
        run_txn(1, 0, 0, '0);
        check("bp_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("bp_first", gnt_log[0], 0);
            check("bp_second", gnt_log[1], 1);
        end

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int cnt;
                cnt = $urandom_range(0, 2);
                for (int c = 0; c < cnt; c++)
                    push(i, 2'($urandom), $urandom, rand_wide());
            end
            while (any_pending())
                run_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), rand_wide());
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end

        // Reset while a read is outstanding.
        push(1, NAT_OP_READ, 32'h40, rand_wide());
        drive_reqs();
        nat_request_ready = 1'b0;
        nat_update_valid  = 1'b0;
        cyc();
        drive_reqs();
        nat_request_ready = 1'b1;
        #3;
        check("rst_mid_req_ready", req_ready, onehot(1));
        cyc();
        hd[1]++;
        push(0, NAT_OP_WRITE, 32'h300, rand_wide());
        drive_reqs();
        nat_request_ready = 1'b1;
        nat_update_valid  = 1'b1;
        upd_ready         = '1;
        upd_ready[1]      = 1'b0;
        nat_update_data   = rand_wide();
        #1;
        check("rst_mid_in_resp", upd_valid, onehot(1));
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        cyc();
        resetn   = 1'b1;
        last_gnt = NUM_REQ - 1;
        gnt_log.delete();
        run_txn(0, 0, 0, '0);
        check("post_rst_grant", gnt_log.size() == 1 ? gnt_log[0] : -1, 0);
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
